tour_cmd_seq: RTL and testbench
===============================

// Module: tour_cmd_seq
// PURPOSE
//  Parametrised successor tour sequencer. Sits between UART_wrapper/TourLogic and cmd_proc.
//  Muxes cmd/cmd_rdy from UART, or takes control (usurp) to replay NUM_MOVES knight moves as 2-leg cmds.
//  Adds over the previous generation: configurable leg order, fanfare policy, abort, illegal-move check,
//  HOLD watchdog timeout, busy/done/err status.
// PARAMETERS
//  NUM_MOVES    24   moves per tour (>=2); last index = NUM_MOVES-1
//  IDX_W        $clog2(NUM_MOVES)  width of mv_indx
//  FAN_MODE     1    0: no fanfare; 1: 2nd leg of every move uses MOVE_FAN; 2: only 2nd leg of final move
//  TIMEOUT_CYC  0    max cycles in a HOLD state awaiting send_resp; 0 disables watchdog
// PORTS
//  clk           in   1      system clock
//  rst           in   1      synchronous active-high reset
//  start_tour    in   1      pulse from TourLogic: begin tour at index 0
//  abort_tour    in   1      pulse: terminate tour, release bus
//  y_first       in   1      1: vertical leg first; 0: 2-square leg first (sampled at start_tour)
//  move          in   8      one-hot move for mv_indx (N2E1=b0,N2W1,W2N1,W2S1,S2W1,S2E1,E2S1,E2N1=b7)
//  mv_indx       out  IDX_W  move index presented to TourLogic
//  cmd_UART      in   16     cmd from UART_wrapper
//  cmd_rdy_UART  in   1      cmd valid from UART_wrapper
//  cmd           out  16     muxed cmd to cmd_proc
//  cmd_rdy       out  1      muxed cmd valid to cmd_proc
//  clr_cmd_rdy   in   1      cmd_proc accepted cmd
//  send_resp     in   1      cmd_proc finished cmd
//  resp          out  8      0xA5 done / 0x5A in progress / 0xEE error
//  tour_busy     out  1      usurp active
//  tour_done     out  1      1-cycle pulse on normal completion
//  tour_err      out  1      sticky: abort, illegal move or timeout; cleared by start_tour or rst
// BEHAVIOUR
//  Reset (sync, takes effect on clk edge with rst=1): state IDLE, mv_indx 0, wdog 0, y_first_q 1,
//   tour_err 0, tour_done 0; hence cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, resp=0xA5 (0xEE never after rst).
//  Cmd format {op[3:0],hdg[7:0],sq[3:0]}; op MOVE=4'h4, MOVE_FAN=4'h5; hdg N=00,E=BF,S=7F,W=3F; sq 1 or 2.
//  Leg decode: e.g. N2E1 -> V={N,2}, H={E,1}; W2S1 -> V={S,1}, H={W,2}. Leg1/leg2 = V/H if y_first_q, else
//   the 2-square leg first. Leg1 op always MOVE; leg2 op per FAN_MODE.
//  FSM: IDLE -> L1_CMD -> L1_HOLD -> L2_CMD -> L2_HOLD -> (L1_CMD | IDLE).
//   IDLE: start_tour -> clr mv_indx, clr tour_err, latch y_first, go L1_CMD. usurp=0 in IDLE only.
//   Lx_CMD: cmd_rdy=1, cmd=leg cmd (combinational on move); clr_cmd_rdy -> Lx_HOLD.
//   Lx_HOLD: cmd held, cmd_rdy=0; send_resp -> next. L2_HOLD: mv_indx==NUM_MOVES-1 -> IDLE + tour_done,
//    else mv_indx+1, go L1_CMD. move is combinational on mv_indx; next leg issues 1 cycle after increment.
//  resp while busy: 0x5A, except 0xA5 when mv_indx==NUM_MOVES-1; resp=0xEE in IDLE while tour_err=1, else 0xA5.
//  Illegal move (not one-hot, incl. 0) in L1_CMD: no cmd_rdy, set tour_err, go IDLE.
//  Watchdog: counts cycles in L1_HOLD/L2_HOLD, cleared on leaving; reaching TIMEOUT_CYC -> tour_err, IDLE.
//  Priority same cycle: rst > abort_tour > illegal/timeout > send_resp/clr_cmd_rdy > start_tour.
//  abort_tour in any non-IDLE state: IDLE next cycle, tour_err=1, no tour_done; ignored in IDLE.
//  start_tour while busy: ignored. mv_indx never wraps; holds NUM_MOVES-1 after completion.
//  UART cmd_rdy_UART while busy: not forwarded (UART_wrapper holds it until cmd_proc clears).
// STRUCTURE
//  tour_pkg: opcode/heading/square localparams, one-hot move enum, leg_t struct {op,hdg,sq},
//   resp codes (RESP_DONE=A5, RESP_BUSY=5A, RESP_ERR=EE).
//  Sub-module tour_leg_decode (comb): move,y_first_q,last,FAN_MODE -> leg1,leg2,illegal.
//  Top: FSM, mv_indx counter, watchdog counter, status regs, output muxes.
// TESTING
//  NUM_MOVES=24,FAN_MODE=1,y_first=1, all N2E1, ack each cmd -> cmds 0x4002,0x5BF1 x24; resp 0x5A then
//   0xA5 at idx 23; tour_done one pulse; mv_indx stays 23.
//  y_first=0, move=W2S1 -> leg1 0x43F2, leg2 0x57F1; FAN_MODE=2 -> leg2 0x47F1 except final move 0x57F1.
//  abort_tour coincident with send_resp in L2_HOLD at idx 5 -> IDLE, mv_indx 5, tour_err=1, resp 0xEE,
//   cmd follows cmd_UART next cycle; new start_tour clears err, mv_indx 0.
//  move=8'h03 at idx 2 -> no cmd_rdy, tour_err=1, IDLE.
//  TIMEOUT_CYC=100, withhold send_resp in L1_HOLD -> tour_err on cycle 100; TIMEOUT_CYC=0 -> waits forever.
//  rst asserted in L2_CMD -> next edge: IDLE, mv_indx 0, cmd_rdy=cmd_rdy_UART; start_tour while busy ignored.

Source files
------------

// File: rtl/tour_pkg.sv
// tour_pkg: shared definitions for the tour command sequencer.
//   - command opcode / heading / square-count encodings
//   - one-hot knight move encoding as presented by TourLogic
//   - leg_t: one leg of a knight move expressed as a cmd_proc command
//   - response codes returned to the host
package tour_pkg;

  // Opcodes
  localparam logic [3:0] OP_MOVE     = 4'h4;
  localparam logic [3:0] OP_MOVE_FAN = 4'h5;

  // Headings
  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_E = 8'hBF;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_W = 8'h3F;

  // Square counts
  localparam logic [3:0] SQ_1 = 4'd1;
  localparam logic [3:0] SQ_2 = 4'd2;

  // One-hot knight moves: first letter/number is the 2-square direction
  typedef enum logic [7:0] {
    MV_N2E1 = 8'h01,
    MV_N2W1 = 8'h02,
    MV_W2N1 = 8'h04,
    MV_W2S1 = 8'h08,
    MV_S2W1 = 8'h10,
    MV_S2E1 = 8'h20,
    MV_E2S1 = 8'h40,
    MV_E2N1 = 8'h80
  } move_e;

  // Command layout {op, hdg, sq}
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] hdg;
    logic [3:0] sq;
  } leg_t;

  // Response codes
  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;
  localparam logic [7:0] RESP_ERR  = 8'hEE;

  // True when exactly one bit is set (zero is not one-hot)
  function automatic logic is_onehot(input logic [7:0] m);
    return (m != 8'h00) && ((m & (m - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/tour_leg_decode.sv
// tour_leg_decode: combinational split of one knight move into two leg commands.
// Ports:
//   move       in  8   one-hot move from TourLogic
//   y_first_q  in  1   1: vertical leg first; 0: 2-square leg first
//   last       in  1   current move is the final move of the tour
//   leg1_cmd   out 16  first leg command (always plain MOVE)
//   leg2_cmd   out 16  second leg command (opcode chosen by FAN_MODE)
//   illegal    out 1   move is not one-hot
module tour_leg_decode
  import tour_pkg::*;
#(
  parameter int FAN_MODE = 1
) (
  input  logic [7:0]  move,
  input  logic        y_first_q,
  input  logic        last,
  output logic [15:0] leg1_cmd,
  output logic [15:0] leg2_cmd,
  output logic        illegal
);

  logic [7:0] v_hdg;
  logic [3:0] v_sq;
  logic [7:0] h_hdg;
  logic [3:0] h_sq;
  leg_t       v_leg;
  leg_t       h_leg;
  leg_t       leg1;
  leg_t       leg2;

  // Vertical (N/S) and horizontal (E/W) components of each move
  always_comb begin
    v_hdg = HDG_N;
    v_sq  = SQ_2;
    h_hdg = HDG_E;
    h_sq  = SQ_1;
    case (move)
      MV_N2E1: begin v_hdg = HDG_N; v_sq = SQ_2; h_hdg = HDG_E; h_sq = SQ_1; end
      MV_N2W1: begin v_hdg = HDG_N; v_sq = SQ_2; h_hdg = HDG_W; h_sq = SQ_1; end
      MV_W2N1: begin v_hdg = HDG_N; v_sq = SQ_1; h_hdg = HDG_W; h_sq = SQ_2; end
      MV_W2S1: begin v_hdg = HDG_S; v_sq = SQ_1; h_hdg = HDG_W; h_sq = SQ_2; end
      MV_S2W1: begin v_hdg = HDG_S; v_sq = SQ_2; h_hdg = HDG_W; h_sq = SQ_1; end
      MV_S2E1: begin v_hdg = HDG_S; v_sq = SQ_2; h_hdg = HDG_E; h_sq = SQ_1; end
      MV_E2S1: begin v_hdg = HDG_S; v_sq = SQ_1; h_hdg = HDG_E; h_sq = SQ_2; end
      MV_E2N1: begin v_hdg = HDG_N; v_sq = SQ_1; h_hdg = HDG_E; h_sq = SQ_2; end
      default: ;
    endcase
  end

  always_comb begin
    v_leg = '{op: OP_MOVE, hdg: v_hdg, sq: v_sq};
    h_leg = '{op: OP_MOVE, hdg: h_hdg, sq: h_sq};

    // Without y_first the 2-square leg goes first, whichever axis it is on
    if (y_first_q || (v_sq == SQ_2)) begin
      leg1 = v_leg;
      leg2 = h_leg;
    end else begin
      leg1 = h_leg;
      leg2 = v_leg;
    end

    leg1.op = OP_MOVE;
    if (FAN_MODE == 1)
      leg2.op = OP_MOVE_FAN;
    else if (FAN_MODE == 2)
      leg2.op = last ? OP_MOVE_FAN : OP_MOVE;
    else
      leg2.op = OP_MOVE;
  end

  assign leg1_cmd = leg1;
  assign leg2_cmd = leg2;
  assign illegal  = !is_onehot(move);

endmodule

// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: knight tour command sequencer between UART_wrapper/TourLogic and cmd_proc.
// When idle it passes the UART command path straight through; during a tour it
// takes over the bus and replays NUM_MOVES moves, each as two leg commands.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start_tour / abort_tour   tour control pulses
//   y_first                   leg order, latched at start_tour
//   move / mv_indx            one-hot move fetched from TourLogic at mv_indx
//   cmd_UART / cmd_rdy_UART   host command path
//   cmd / cmd_rdy             muxed command to cmd_proc
//   clr_cmd_rdy / send_resp   cmd_proc accept / finish handshakes
//   resp                      status byte (done / in progress / error)
//   tour_busy / tour_done / tour_err  status
module tour_cmd_seq
  import tour_pkg::*;
#(
  parameter int NUM_MOVES   = 24,
  parameter int IDX_W       = $clog2(NUM_MOVES),
  parameter int FAN_MODE    = 1,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic             abort_tour,
  input  logic             y_first,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy,
  output logic             tour_done,
  output logic             tour_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_CMD,
    S_L1_HOLD,
    S_L2_CMD,
    S_L2_HOLD
  } state_e;

  localparam int                WD_W     = $clog2(TIMEOUT_CYC + 1) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MOVES - 1);
  localparam logic [WD_W-1:0]   WD_LAST  = (TIMEOUT_CYC == 0) ? '0 : WD_W'(TIMEOUT_CYC - 1);

  state_e          state;
  logic [WD_W-1:0] wdog;
  logic            y_first_q;
  logic            err_q;
  logic            done_q;

  logic            last;
  logic            in_hold;
  logic            timeout;
  logic            illegal;
  logic [15:0]     leg1_cmd;
  logic [15:0]     leg2_cmd;

  assign last    = (mv_indx == LAST_IDX);
  assign in_hold = (state == S_L1_HOLD) || (state == S_L2_HOLD);
  // wdog reaches TIMEOUT_CYC-1 during the TIMEOUT_CYC-th hold cycle
  assign timeout = (TIMEOUT_CYC != 0) && in_hold && (wdog == WD_LAST);

  tour_leg_decode #(
    .FAN_MODE (FAN_MODE)
  ) u_leg_decode (
    .move      (move),
    .y_first_q (y_first_q),
    .last      (last),
    .leg1_cmd  (leg1_cmd),
    .leg2_cmd  (leg2_cmd),
    .illegal   (illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mv_indx   <= '0;
      wdog      <= '0;
      y_first_q <= 1'b1;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_tour && (state != S_IDLE)) begin
        state <= S_IDLE;
        err_q <= 1'b1;
        wdog  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_tour) begin
              mv_indx   <= '0;
              err_q     <= 1'b0;
              y_first_q <= y_first;
              state     <= S_L1_CMD;
            end
          end
          S_L1_CMD: begin
            if (illegal) begin
              err_q <= 1'b1;
              state <= S_IDLE;
            end else if (clr_cmd_rdy) begin
              state <= S_L1_HOLD;
            end
          end
          S_L1_HOLD: begin
            if (timeout) begin
              err_q <= 1'b1;
              wdog  <= '0;
              state <= S_IDLE;
            end else if (send_resp) begin
              wdog  <= '0;
              state <= S_L2_CMD;
            end else if (TIMEOUT_CYC != 0) begin
              wdog <= wdog + 1'b1;
            end
          end
          S_L2_CMD: begin
            if (clr_cmd_rdy)
              state <= S_L2_HOLD;
          end
          S_L2_HOLD: begin
            if (timeout) begin
              err_q <= 1'b1;
              wdog  <= '0;
              state <= S_IDLE;
            end else if (send_resp) begin
              wdog <= '0;
              // mv_indx is left at the last index after completion
              if (last) begin
                done_q <= 1'b1;
                state  <= S_IDLE;
              end else begin
                mv_indx <= mv_indx + 1'b1;
                state   <= S_L1_CMD;
              end
            end else if (TIMEOUT_CYC != 0) begin
              wdog <= wdog + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Output mux: UART pass-through when idle, leg commands while touring
  always_comb begin
    cmd     = cmd_UART;
    cmd_rdy = cmd_rdy_UART;
    resp    = err_q ? RESP_ERR : RESP_DONE;
    if (state != S_IDLE)
      resp = last ? RESP_DONE : RESP_BUSY;
    case (state)
      S_L1_CMD: begin
        cmd     = leg1_cmd;
        cmd_rdy = !illegal;
      end
      S_L1_HOLD: begin
        cmd     = leg1_cmd;
        cmd_rdy = 1'b0;
      end
      S_L2_CMD: begin
        cmd     = leg2_cmd;
        cmd_rdy = 1'b1;
      end
      S_L2_HOLD: begin
        cmd     = leg2_cmd;
        cmd_rdy = 1'b0;
      end
      default: ;
    endcase
  end

  assign tour_busy = (state != S_IDLE);
  assign tour_done = done_q;
  assign tour_err  = err_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
module tb_tour_cmd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic        abort_tour;
  logic        y_first;
  logic [7:0]  move;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;

  logic [4:0]  mv_indx_a, mv_indx_b;
  logic [15:0] cmd_a, cmd_b;
  logic        cmd_rdy_a, cmd_rdy_b;
  logic [7:0]  resp_a, resp_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;

  logic [7:0]  tour_moves [0:31];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // TourLogic model: move table looked up by the presented index
  always_comb move = tour_moves[mv_indx_a];

  // Instance A: fanfare on every 2nd leg, no watchdog
  tour_cmd_seq #(.NUM_MOVES(24), .FAN_MODE(1), .TIMEOUT_CYC(0)) dut_a (
    .clk(clk), .rst(rst), .start_tour(start_tour), .abort_tour(abort_tour),
    .y_first(y_first), .move(move), .mv_indx(mv_indx_a),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .cmd(cmd_a), .cmd_rdy(cmd_rdy_a),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp_a),
    .tour_busy(busy_a), .tour_done(done_a), .tour_err(err_a));

  // Instance B: fanfare only on final move, 100-cycle watchdog
  tour_cmd_seq #(.NUM_MOVES(24), .FAN_MODE(2), .TIMEOUT_CYC(100)) dut_b (
    .clk(clk), .rst(rst), .start_tour(start_tour), .abort_tour(abort_tour),
    .y_first(y_first), .move(8'h00 | move), .mv_indx(mv_indx_b),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .cmd(cmd_b), .cmd_rdy(cmd_rdy_b),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp_b),
    .tour_busy(busy_b), .tour_done(done_b), .tour_err(err_b));

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_moves(input logic [7:0] m);
    for (int k = 0; k < 32; k++) tour_moves[k] = m;
  endtask

  task automatic start_pulse(input logic yf);
    y_first = yf;
    start_tour = 1'b1;
    cyc();
    start_tour = 1'b0;
  endtask

  // One complete move handshake: L1_CMD -> L1_HOLD -> L2_CMD -> L2_HOLD -> next
  task automatic adv_move();
    clr_cmd_rdy = 1'b1; cyc(); clr_cmd_rdy = 1'b0;
    send_resp   = 1'b1; cyc(); send_resp   = 1'b0;
    clr_cmd_rdy = 1'b1; cyc(); clr_cmd_rdy = 1'b0;
    send_resp   = 1'b1; cyc(); send_resp   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_tour = 1'b0; abort_tour = 1'b0; y_first = 1'b1;
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    fill_moves(8'h01);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    n_checks++; if (busy_a !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy_a); else n_pass++;
    n_checks++; if (mv_indx_a !== 5'd0) $display("FAIL rst_mv_indx got=%0d exp=0", mv_indx_a); else n_pass++;
    n_checks++; if (cmd_a !== 16'h1234) $display("FAIL rst_cmd got=%h exp=1234", cmd_a); else n_pass++;
    n_checks++; if (cmd_rdy_a !== 1'b1) $display("FAIL rst_cmd_rdy got=%b exp=1", cmd_rdy_a); else n_pass++;
    n_checks++; if (resp_a !== 8'hA5) $display("FAIL rst_resp got=%h exp=a5", resp_a); else n_pass++;
    n_checks++; if (err_a !== 1'b0 || err_b !== 1'b0) $display("FAIL rst_err got=%b%b exp=00", err_a, err_b); else n_pass++;
    n_checks++; if (done_a !== 1'b0) $display("FAIL rst_done got=%b exp=0", done_a); else n_pass++;
    // abort while idle is ignored
    abort_tour = 1'b1; cyc(); abort_tour = 1'b0;
    n_checks++; if (err_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL idle_abort err=%b busy=%b exp=0,0", err_a, busy_a); else n_pass++;
  endtask

  task automatic test_tour(input string nm, input logic yf, input logic [7:0] mv,
                           input logic [15:0] e_l1, input logic [15:0] e_l2a,
                           input logic [15:0] e_l2b, input logic [15:0] e_l2b_last);
    logic [7:0]  e_resp;
    logic [15:0] e_b;
    fill_moves(mv);
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1;
    start_pulse(yf);
    for (int i = 0; i < 24; i++) begin
      e_resp = (i == 23) ? 8'hA5 : 8'h5A;
      e_b    = (i == 23) ? e_l2b_last : e_l2b;
      n_checks++; if (mv_indx_a !== 5'(i) || busy_a !== 1'b1) $display("FAIL %s_idx got=%0d busy=%b exp=%0d,1", nm, mv_indx_a, busy_a, i); else n_pass++;
      n_checks++; if (cmd_rdy_a !== 1'b1 || cmd_a !== e_l1 || cmd_b !== e_l1) $display("FAIL %s_leg1 idx=%0d got=%h/%h rdy=%b exp=%h", nm, i, cmd_a, cmd_b, cmd_rdy_a, e_l1); else n_pass++;
      n_checks++; if (resp_a !== e_resp) $display("FAIL %s_resp idx=%0d got=%h exp=%h", nm, i, resp_a, e_resp); else n_pass++;
      clr_cmd_rdy = 1'b1; cyc(); clr_cmd_rdy = 1'b0;
      n_checks++; if (cmd_rdy_a !== 1'b0 || cmd_a !== e_l1) $display("FAIL %s_hold1 idx=%0d got=%h rdy=%b exp=%h,0", nm, i, cmd_a, cmd_rdy_a, e_l1); else n_pass++;
      send_resp = 1'b1; cyc(); send_resp = 1'b0;
      n_checks++; if (cmd_rdy_a !== 1'b1 || cmd_a !== e_l2a) $display("FAIL %s_leg2a idx=%0d got=%h rdy=%b exp=%h", nm, i, cmd_a, cmd_rdy_a, e_l2a); else n_pass++;
      n_checks++; if (cmd_b !== e_b) $display("FAIL %s_leg2b idx=%0d got=%h exp=%h", nm, i, cmd_b, e_b); else n_pass++;
      clr_cmd_rdy = 1'b1; cyc(); clr_cmd_rdy = 1'b0;
      n_checks++; if (cmd_rdy_b !== 1'b0 || done_a !== 1'b0) $display("FAIL %s_hold2 idx=%0d rdy=%b done=%b exp=0,0", nm, i, cmd_rdy_b, done_a); else n_pass++;
      send_resp = 1'b1; cyc(); send_resp = 1'b0;
    end
    n_checks++; if (done_a !== 1'b1 || done_b !== 1'b1) $display("FAIL %s_done got=%b%b exp=11", nm, done_a, done_b); else n_pass++;
    n_checks++; if (busy_a !== 1'b0 || mv_indx_a !== 5'd23) $display("FAIL %s_end busy=%b idx=%0d exp=0,23", nm, busy_a, mv_indx_a); else n_pass++;
    n_checks++; if (resp_a !== 8'hA5 || cmd_a !== 16'h1234 || cmd_rdy_a !== 1'b1) $display("FAIL %s_release resp=%h cmd=%h rdy=%b exp=a5,1234,1", nm, resp_a, cmd_a, cmd_rdy_a); else n_pass++;
    cyc();
    n_checks++; if (done_a !== 1'b0 || mv_indx_a !== 5'd23) $display("FAIL %s_done_pulse done=%b idx=%0d exp=0,23", nm, done_a, mv_indx_a); else n_pass++;
  endtask

  task automatic test_abort();
    fill_moves(8'h01);
    start_pulse(1'b1);
    repeat (5) adv_move();
    clr_cmd_rdy = 1'b1; cyc(); clr_cmd_rdy = 1'b0;
    send_resp   = 1'b1; cyc(); send_resp   = 1'b0;
    clr_cmd_rdy = 1'b1; cyc(); clr_cmd_rdy = 1'b0;
    // now in L2_HOLD at index 5: abort wins over send_resp
    cmd_UART = 16'hBEEF; cmd_rdy_UART = 1'b0;
    send_resp = 1'b1; abort_tour = 1'b1; cyc(); send_resp = 1'b0; abort_tour = 1'b0;
    n_checks++; if (busy_a !== 1'b0 || mv_indx_a !== 5'd5) $display("FAIL abort_state busy=%b idx=%0d exp=0,5", busy_a, mv_indx_a); else n_pass++;
    n_checks++; if (err_a !== 1'b1 || resp_a !== 8'hEE || done_a !== 1'b0) $display("FAIL abort_err err=%b resp=%h done=%b exp=1,ee,0", err_a, resp_a, done_a); else n_pass++;
    n_checks++; if (cmd_a !== 16'hBEEF || cmd_rdy_a !== 1'b0) $display("FAIL abort_release cmd=%h rdy=%b exp=beef,0", cmd_a, cmd_rdy_a); else n_pass++;
    start_pulse(1'b1);
    n_checks++; if (err_a !== 1'b0 || mv_indx_a !== 5'd0 || busy_a !== 1'b1 || resp_a !== 8'h5A) $display("FAIL restart err=%b idx=%0d busy=%b resp=%h exp=0,0,1,5a", err_a, mv_indx_a, busy_a, resp_a); else n_pass++;
    adv_move();
    // start while busy is ignored
    start_tour = 1'b1; cyc(); start_tour = 1'b0;
    n_checks++; if (mv_indx_a !== 5'd1 || cmd_rdy_a !== 1'b1 || cmd_a !== 16'h4002) $display("FAIL busy_start idx=%0d rdy=%b cmd=%h exp=1,1,4002", mv_indx_a, cmd_rdy_a, cmd_a); else n_pass++;
    abort_tour = 1'b1; cyc(); abort_tour = 1'b0;
    n_checks++; if (busy_a !== 1'b0 || err_a !== 1'b1) $display("FAIL abort_l1 busy=%b err=%b exp=0,1", busy_a, err_a); else n_pass++;
  endtask

  task automatic test_illegal();
    fill_moves(8'h01);
    tour_moves[2] = 8'h03;
    cmd_rdy_UART = 1'b1;
    start_pulse(1'b1);
    n_checks++; if (err_a !== 1'b0) $display("FAIL illegal_clr err=%b exp=0", err_a); else n_pass++;
    repeat (2) adv_move();
    n_checks++; if (cmd_rdy_a !== 1'b0 || busy_a !== 1'b1 || mv_indx_a !== 5'd2) $display("FAIL illegal_rdy rdy=%b busy=%b idx=%0d exp=0,1,2", cmd_rdy_a, busy_a, mv_indx_a); else n_pass++;
    clr_cmd_rdy = 1'b1; cyc(); clr_cmd_rdy = 1'b0;
    n_checks++; if (busy_a !== 1'b0 || err_a !== 1'b1 || resp_a !== 8'hEE || err_b !== 1'b1) $display("FAIL illegal_err busy=%b err=%b%b resp=%h exp=0,11,ee", busy_a, err_a, err_b, resp_a); else n_pass++;
    tour_moves[2] = 8'h01;
  endtask

  task automatic test_timeout();
    fill_moves(8'h01);
    start_pulse(1'b1);
    clr_cmd_rdy = 1'b1; cyc(); clr_cmd_rdy = 1'b0;
    // first L1_HOLD cycle; send_resp withheld from here on
    repeat (99) cyc();
    n_checks++; if (busy_b !== 1'b1 || err_b !== 1'b0) $display("FAIL wdog_early busy=%b err=%b exp=1,0", busy_b, err_b); else n_pass++;
    cyc();
    n_checks++; if (busy_b !== 1'b0 || err_b !== 1'b1 || resp_b !== 8'hEE) $display("FAIL wdog_fire busy=%b err=%b resp=%h exp=0,1,ee", busy_b, err_b, resp_b); else n_pass++;
    n_checks++; if (busy_a !== 1'b1 || err_a !== 1'b0) $display("FAIL wdog_off100 busy=%b err=%b exp=1,0", busy_a, err_a); else n_pass++;
    repeat (200) cyc();
    n_checks++; if (busy_a !== 1'b1 || err_a !== 1'b0 || cmd_a !== 16'h4002) $display("FAIL wdog_off300 busy=%b err=%b cmd=%h exp=1,0,4002", busy_a, err_a, cmd_a); else n_pass++;
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  task automatic test_rst_mid();
    fill_moves(8'h01);
    cmd_UART = 16'h0F0F; cmd_rdy_UART = 1'b1;
    start_pulse(1'b1);
    repeat (3) adv_move();
    clr_cmd_rdy = 1'b1; cyc(); clr_cmd_rdy = 1'b0;
    send_resp   = 1'b1; cyc(); send_resp   = 1'b0;
    n_checks++; if (cmd_rdy_a !== 1'b1 || cmd_a !== 16'h5BF1 || mv_indx_a !== 5'd3) $display("FAIL mid_l2 rdy=%b cmd=%h idx=%0d exp=1,5bf1,3", cmd_rdy_a, cmd_a, mv_indx_a); else n_pass++;
    cmd_rdy_UART = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    n_checks++; if (busy_a !== 1'b0 || mv_indx_a !== 5'd0) $display("FAIL mid_rst busy=%b idx=%0d exp=0,0", busy_a, mv_indx_a); else n_pass++;
    n_checks++; if (cmd_rdy_a !== 1'b0 || cmd_a !== 16'h0F0F || resp_a !== 8'hA5) $display("FAIL mid_rst_out rdy=%b cmd=%h resp=%h exp=0,0f0f,a5", cmd_rdy_a, cmd_a, resp_a); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tour("n2e1_yf1", 1'b1, 8'h01, 16'h4002, 16'h5BF1, 16'h4BF1, 16'h5BF1);
    test_tour("w2s1_yf0", 1'b0, 8'h08, 16'h43F2, 16'h57F1, 16'h47F1, 16'h57F1);
    test_tour("s2w1_yf1", 1'b1, 8'h10, 16'h47F2, 16'h53F1, 16'h43F1, 16'h53F1);
    test_abort();
    test_illegal();
    test_timeout();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end

endmodule
